uart_fifo_mapped: RTL
=====================

// Module: uart_fifo_mapped
// PURPOSE
//  Memory-mapped full-duplex 8N1 UART for the SOC IO page. Successor to the fixed-rate TX-only emitter.
//  Adds parametrised TX/RX FIFOs, a runtime baud divisor, an RX path with framing/overrun detection, and an IRQ.
//  Sits behind the SOC IO decode: the SOC drives sel from isIO plus its word-address decode.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD_RATE    1_000_000    reset baud; DIVISOR resets to CLK_FREQ_HZ/BAUD_RATE
//  TX_DEPTH     16           TX FIFO entries; power of 2, >=2
//  RX_DEPTH     16           RX FIFO entries; power of 2, >=2
//  DIV_WIDTH    16           divisor register width
// PORTS
//  clk     in   1   system clock
//  resetn  in   1   asynchronous active-low reset
//  sel     in   1   peripheral selected this cycle
//  addr    in   2   register index: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL
//  wdata   in   32  write data
//  wstrb   in   1   write strobe; effective only when sel=1
//  rstrb   in   1   read strobe; effective only when sel=1
//  rdata   out  32  read data, registered
//  rxd     in   1   serial in, asynchronous
//  txd     out  1   serial out, idle high
//  irq     out  1   level interrupt
// BEHAVIOUR
//  Reset (async):
//   - txd=1, rdata=0, irq=0; both FIFOs empty; sticky flags 0; CTRL=0; DIVISOR=CLK_FREQ_HZ/BAUD_RATE.
//   - A mid-frame reset aborts the frame at once; txd goes high asynchronously.
//  Read: rdata is updated on the clk edge where sel&rstrb=1 (1-cycle latency) and held until the next read.
//   DATA    {23'b0, valid, byte}; pops RX only if non-empty. Empty -> 0, no pop.
//   STATUS  [0] rx_nonempty [1] rx_full [2] tx_empty [3] rx_overrun [4] rx_frame_err [5] tx_overflow
//           [8] tx_active [9] tx_full. Bit 9 keeps the legacy "busy" poll working.
//   DIVISOR {0, div}
//   CTRL    [0] rx_ie [1] tx_ie
//  Write (sel&wstrb):
//   DATA    pushes wdata[7:0] to TX. If full with no pop that cycle -> byte dropped, tx_overflow set.
//   STATUS  write-1-to-clear of bits [5:3].
//   DIVISOR values <2 are clamped to 2. Takes effect at the next frame start/edge; in-flight frames keep a latched copy.
//   CTRL    [1:0].
//   sel&rstrb&wstrb in the same cycle: the write is applied and rdata returns the pre-write value.
//  FIFOs: push+pop in the same cycle when full -> both happen, count unchanged. Push when empty -> pop blocked that cycle.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each state lasts div cycles.
//   - Leaves IDLE the cycle after TX becomes non-empty; the pop happens at IDLE->START.
//   - Back-to-back frames have no idle gap. tx_active=1 outside IDLE.
//  RX:
//   - rxd passes a 2-FF synchroniser. IDLE waits for a falling edge, then START waits div/2 cycles.
//   - If the line is high at that point it is a glitch -> return to IDLE.
//   - DATA samples 8 bits at div intervals; STOP samples at +div.
//   - Stop=0: byte discarded, rx_frame_err set, wait for line high before IDLE.
//   - Stop=1: push. If RX is full -> byte dropped, rx_overrun set.
//  irq = (rx_ie & rx_nonempty) | (tx_ie & tx_empty), registered (1-cycle lag).
//  Baud counters are DIV_WIDTH bits, count down to 1, and reload; no wrap beyond the reload.
// STRUCTURE
//  - uart_defs.vh: register offsets, STATUS/CTRL bit positions, FSM state encodings (shared with firmware headers).
//  - Sub-module sync_fifo #(WIDTH,DEPTH): registered count, full/empty, same-cycle push/pop; instantiated for TX (8b) and RX (8b).
//  - Top level holds the register file, TX FSM, RX FSM and synchroniser.
// TESTING (CLK_FREQ_HZ=1000, BAUD_RATE=100 -> div=10, depths 4)
//  1. Reset mid-TX of 0xA5 -> txd=1 within the reset cycle; STATUS reads 0x004; DIVISOR reads 10.
//  2. Write DATA 0x55 -> txd low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, stop 10; tx_active falls after 100.
//  3. Write 6 bytes fast -> the first is popped immediately; after 4 more TX is full (STATUS[9]=1);
//     the 6th is dropped and sets STATUS[5]; W1C 0x20 clears it.
//  4. Drive 0x3C on rxd at div=10 -> STATUS[0]=1; DATA read returns 0x13C; a 2nd read returns 0x000.
//  5. Drive 5 frames with no reads -> 4 stored, STATUS[3]=1; a frame with stop=0 -> STATUS[4]=1, count unchanged;
//     a 3-cycle low glitch -> nothing stored.
//  6. CTRL=1, receive a byte -> irq=1; write DIVISOR=1 -> reads 2; a divisor change mid-frame leaves that frame at the old rate.

Source files
------------

// File: rtl/uart_fifo_mapped_pkg.sv
// Purpose: shared definitions for the memory-mapped UART. This covers register
//          offsets, STATUS/CTRL bit positions, FSM state encodings and a STATUS
//          packing helper. Firmware headers mirror these values.
// Ports:   none (package).
package uart_fifo_mapped_pkg;

    // Register offsets within the peripheral's word window
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_RX_FRAMEERR = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_TX_ACTIVE   = 8;
    localparam int ST_TX_FULL     = 9;

    // CTRL bit positions
    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rxState_e;

    // Assemble the STATUS word from its individual flags
    function automatic logic [31:0] packStatus(
        input logic rxNonEmpty,
        input logic rxFull,
        input logic txEmpty,
        input logic rxOverrun,
        input logic rxFrameErr,
        input logic txOverflow,
        input logic txActive,
        input logic txFull
    );
        logic [31:0] s;
        s                 = '0;
        s[ST_RX_NONEMPTY] = rxNonEmpty;
        s[ST_RX_FULL]     = rxFull;
        s[ST_TX_EMPTY]    = txEmpty;
        s[ST_RX_OVERRUN]  = rxOverrun;
        s[ST_RX_FRAMEERR] = rxFrameErr;
        s[ST_TX_OVERFLOW] = txOverflow;
        s[ST_TX_ACTIVE]   = txActive;
        s[ST_TX_FULL]     = txFull;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_mapped_if.sv
// Purpose: register bus between the SOC IO decode (master) and the UART (slave).
// Signals: sel   - peripheral selected this cycle
//          addr  - register index (DATA/STATUS/DIVISOR/CTRL)
//          wdata - write data
//          wstrb - write strobe, qualified by sel
//          rstrb - read strobe, qualified by sel
//          rdata - registered read data returned by the UART
interface uart_fifo_mapped_if;
    import uart_fifo_mapped_pkg::*;

    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic        rstrb;
    logic [31:0] rdata;

    modport master (output sel, addr, wdata, wstrb, rstrb, input rdata);
    modport slave  (input sel, addr, wdata, wstrb, rstrb, output rdata);

endinterface

// File: rtl/uart_fifo_mapped_fifo.sv
// Purpose: synchronous FIFO with a registered occupancy count. It supports
//          simultaneous push and pop, including when the FIFO is full.
// Ports:   clk_i/rst_ni - clock, asynchronous active-low reset
//          push_i/data_i - push request and data; ignored when full unless popping
//          pop_i/data_o  - pop request and current head; ignored when empty
//          empty_o/full_o - occupancy flags derived from the registered count
module uart_fifo_mapped_fifo
    import uart_fifo_mapped_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign data_o  = mem_q[rdPtr_q];

    // A pop on an empty FIFO is ignored, which also covers the push-while-empty
    // case. A push on a full FIFO lands only if a pop frees the slot this cycle.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/uart_fifo_mapped.sv
// Purpose: memory-mapped full-duplex 8N1 UART with TX/RX FIFOs, a runtime baud
//          divisor, RX framing and overrun detection, and a level interrupt.
// Ports:   clk_i  - system clock
//          rst_ni - asynchronous active-low reset
//          bus    - register bus (slave modport): sel, addr, wdata, wstrb, rstrb, rdata
//          rxd_i  - serial input (asynchronous)
//          txd_o  - serial output, idle high
//          irq_o  - level interrupt, registered
module uart_fifo_mapped
    import uart_fifo_mapped_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 1_000_000,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    uart_fifo_mapped_if.slave    bus,
    input  logic                 rxd_i,
    output logic                 txd_o,
    output logic                 irq_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLK_FREQ_HZ / BAUD_RATE);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    logic busRd;
    logic busWr;
    assign busRd = bus.sel & bus.rstrb;
    assign busWr = bus.sel & bus.wstrb;

    // Register file state
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [1:0]           ctrl_q, ctrl_d;
    logic                 overrun_q, overrun_d;
    logic                 frameErr_q, frameErr_d;
    logic                 txOverflow_q, txOverflow_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q;

    // FIFO hookup
    logic       txPush, txPop, txEmpty, txFull;
    logic [7:0] txHead;
    logic       rxPush, rxPop, rxEmpty, rxFull;
    logic [7:0] rxHead;

    // TX engine state
    txState_e             txState_q;
    logic [DIV_WIDTH-1:0] txCnt_q;
    logic [DIV_WIDTH-1:0] txDiv_q;
    logic [7:0]           txShift_q;
    logic [2:0]           txBit_q;
    logic                 txd_q;
    logic                 txCntDone;
    logic                 txStartFrame;

    // RX engine state
    logic                 rxSync1_q, rxSync2_q, rxPrev_q;
    rxState_e             rxState_q;
    logic [DIV_WIDTH-1:0] rxCnt_q;
    logic [DIV_WIDTH-1:0] rxDiv_q;
    logic [7:0]           rxShift_q;
    logic [2:0]           rxBit_q;
    logic                 rxCntDone;
    logic                 rxFrameErrSet;
    logic                 rxOverrunSet;
    logic                 txOverflowSet;

    assign txPush = busWr & (bus.addr == REG_DATA);
    assign rxPop  = busRd & (bus.addr == REG_DATA) & ~rxEmpty;

    uart_fifo_mapped_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (txPush),
        .data_i  (bus.wdata[7:0]),
        .pop_i   (txPop),
        .data_o  (txHead),
        .empty_o (txEmpty),
        .full_o  (txFull)
    );

    uart_fifo_mapped_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rxFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rxPush),
        .data_i  (rxShift_q),
        .pop_i   (rxPop),
        .data_o  (rxHead),
        .empty_o (rxEmpty),
        .full_o  (rxFull)
    );

    // A frame starts from IDLE or directly out of a finished STOP bit, so
    // back-to-back bytes go out without an idle gap
    assign txCntDone    = (txCnt_q == DIV_ONE);
    assign txStartFrame = ~txEmpty & ((txState_q == TX_IDLE) ||
                                      ((txState_q == TX_STOP) && txCntDone));
    assign txPop        = txStartFrame;

    // The divisor is latched at frame start, so writes to DIVISOR never
    // disturb a frame already on the wire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txDiv_q   <= DIV_RESET;
            txShift_q <= '0;
            txBit_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (txState_q)
                TX_IDLE: begin
                    if (txStartFrame) begin
                        txState_q <= TX_START;
                        txd_q     <= 1'b0;
                        txShift_q <= txHead;
                        txDiv_q   <= div_q;
                        txCnt_q   <= div_q;
                    end
                end
                TX_START: begin
                    if (txCntDone) begin
                        txState_q <= TX_DATA;
                        txd_q     <= txShift_q[0];
                        txBit_q   <= '0;
                        txCnt_q   <= txDiv_q;
                    end else begin
                        txCnt_q <= txCnt_q - DIV_ONE;
                    end
                end
                TX_DATA: begin
                    if (txCntDone) begin
                        txCnt_q <= txDiv_q;
                        if (txBit_q == 3'd7) begin
                            txState_q <= TX_STOP;
                            txd_q     <= 1'b1;
                        end else begin
                            txBit_q   <= txBit_q + 3'd1;
                            txShift_q <= {1'b0, txShift_q[7:1]};
                            txd_q     <= txShift_q[1];
                        end
                    end else begin
                        txCnt_q <= txCnt_q - DIV_ONE;
                    end
                end
                TX_STOP: begin
                    if (txCntDone) begin
                        if (txStartFrame) begin
                            txState_q <= TX_START;
                            txd_q     <= 1'b0;
                            txShift_q <= txHead;
                            txDiv_q   <= div_q;
                            txCnt_q   <= div_q;
                        end else begin
                            txState_q <= TX_IDLE;
                        end
                    end else begin
                        txCnt_q <= txCnt_q - DIV_ONE;
                    end
                end
                default: txState_q <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxPrev_q  <= 1'b1;
        end else begin
            rxSync1_q <= rxd_i;
            rxSync2_q <= rxSync1_q;
            rxPrev_q  <= rxSync2_q;
        end
    end

    assign rxCntDone     = (rxCnt_q == DIV_ONE);
    assign rxPush        = (rxState_q == RX_STOP) & rxCntDone & rxSync2_q;
    assign rxFrameErrSet = (rxState_q == RX_STOP) & rxCntDone & ~rxSync2_q;
    assign rxOverrunSet  = rxPush & rxFull & ~rxPop;
    assign txOverflowSet = txPush & txFull & ~txPop;

    // START waits half a bit so every later sample lands mid-bit. A line that
    // is high again at that point was only a glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxDiv_q   <= DIV_RESET;
            rxShift_q <= '0;
            rxBit_q   <= '0;
        end else begin
            case (rxState_q)
                RX_IDLE: begin
                    if (rxPrev_q && !rxSync2_q) begin
                        rxState_q <= RX_START;
                        rxDiv_q   <= div_q;
                        rxCnt_q   <= {1'b0, div_q[DIV_WIDTH-1:1]};
                    end
                end
                RX_START: begin
                    if (rxCntDone) begin
                        if (rxSync2_q) begin
                            rxState_q <= RX_IDLE;
                        end else begin
                            rxState_q <= RX_DATA;
                            rxBit_q   <= '0;
                            rxCnt_q   <= rxDiv_q;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - DIV_ONE;
                    end
                end
                RX_DATA: begin
                    if (rxCntDone) begin
                        rxShift_q <= {rxSync2_q, rxShift_q[7:1]};
                        rxCnt_q   <= rxDiv_q;
                        if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
                        else                 rxBit_q   <= rxBit_q + 3'd1;
                    end else begin
                        rxCnt_q <= rxCnt_q - DIV_ONE;
                    end
                end
                RX_STOP: begin
                    if (rxCntDone) begin
                        rxState_q <= rxSync2_q ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rxCnt_q <= rxCnt_q - DIV_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxSync2_q) rxState_q <= RX_IDLE;
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    // Register file. Reads sample the pre-write state, so a combined
    // read+write returns the old value. A sticky-flag set wins over a
    // same-cycle clear.
    always_comb begin
        div_d        = div_q;
        ctrl_d       = ctrl_q;
        overrun_d    = overrun_q;
        frameErr_d   = frameErr_q;
        txOverflow_d = txOverflow_q;
        rdata_d      = rdata_q;

        if (busRd) begin
            case (bus.addr)
                REG_DATA:    rdata_d = rxEmpty ? 32'd0 : {23'd0, 1'b1, rxHead};
                REG_STATUS:  rdata_d = packStatus(~rxEmpty, rxFull, txEmpty, overrun_q,
                                                  frameErr_q, txOverflow_q,
                                                  txState_q != TX_IDLE, txFull);
                REG_DIVISOR: rdata_d = 32'(div_q);
                default:     rdata_d = {30'd0, ctrl_q};
            endcase
        end

        if (busWr) begin
            case (bus.addr)
                REG_STATUS: begin
                    if (bus.wdata[ST_RX_OVERRUN])  overrun_d    = 1'b0;
                    if (bus.wdata[ST_RX_FRAMEERR]) frameErr_d   = 1'b0;
                    if (bus.wdata[ST_TX_OVERFLOW]) txOverflow_d = 1'b0;
                end
                REG_DIVISOR: div_d = (bus.wdata < 32'd2) ? DIV_WIDTH'(2)
                                                         : bus.wdata[DIV_WIDTH-1:0];
                REG_CTRL:    ctrl_d = bus.wdata[1:0];
                default:     ;
            endcase
        end

        if (rxOverrunSet)  overrun_d    = 1'b1;
        if (rxFrameErrSet) frameErr_d   = 1'b1;
        if (txOverflowSet) txOverflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q        <= DIV_RESET;
            ctrl_q       <= '0;
            overrun_q    <= 1'b0;
            frameErr_q   <= 1'b0;
            txOverflow_q <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            div_q        <= div_d;
            ctrl_q       <= ctrl_d;
            overrun_q    <= overrun_d;
            frameErr_q   <= frameErr_d;
            txOverflow_q <= txOverflow_d;
            rdata_q      <= rdata_d;
            irq_q        <= (ctrl_q[CTRL_RX_IE] & ~rxEmpty) | (ctrl_q[CTRL_TX_IE] & txEmpty);
        end
    end

    assign bus.rdata = rdata_q;
    assign txd_o     = txd_q;
    assign irq_o     = irq_q;

endmodule
